// File: rtl/fres_trim_sar.sv
// fres_trim_sar: successive-approximation trim controller for a resistor model.
// Define FRES_TRIM_MAJ_EN for 2-of-3 majority comparator sampling.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse, begins a calibration when idle
//   cmp                 comparator result from the analog side
//   ovr_en, ovr_code    manual override of the applied code
//   code_out, rval      applied code and its resistance in ohms
//   busy, done, result  calibration status and last resolved code
module fres_trim_sar #(
  parameter int  CODE_W  = 6,
  parameter real RMIN    = 100.0,
  parameter real RSTEP   = 10.0,
  parameter int  SETTLE  = 4,
  parameter int  CMP_POL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp,
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
  output logic [CODE_W-1:0] code_out,
  output real               rval,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] result
);

  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic POL = (CMP_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    SAMPLE
  } state_t;

  state_t            state;
  logic [BW-1:0]     b;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] bmask;
  logic [CODE_W-1:0] nxt;
  logic              hit;
  logic              clr;
  logic              last;

`ifdef FRES_TRIM_MAJ_EN
  logic [1:0] smp;
  logic [1:0] votes;

  // third sample cycle closes the vote
  assign last = (smp == 2'd2);
  assign clr  = (votes + {1'b0, hit}) >= 2'd2;
`else
  assign last = 1'b1;
  assign clr  = hit;
`endif

  assign bmask = {{(CODE_W-1){1'b0}}, 1'b1} << b;
  assign hit   = (cmp == POL);
  assign nxt   = clr ? (code_out & ~bmask) : code_out;
  assign rval  = RMIN + $itor(code_out) * RSTEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      b        <= '0;
      cnt      <= '0;
`ifdef FRES_TRIM_MAJ_EN
      smp      <= '0;
      votes    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !ovr_en) begin
            state    <= TRIAL;
            code_out <= {1'b1, {(CODE_W-1){1'b0}}};
            b        <= BW'(CODE_W-1);
            cnt      <= CW'(SETTLE-1);
            busy     <= 1'b1;
          end else begin
            code_out <= ovr_en ? ovr_code : result;
          end
        end
        TRIAL: begin
          if (ovr_en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            code_out <= ovr_code;
          end else if (cnt == '0) begin
            state <= SAMPLE;
`ifdef FRES_TRIM_MAJ_EN
            smp   <= '0;
            votes <= '0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (ovr_en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            code_out <= ovr_code;
          end else if (!last) begin
`ifdef FRES_TRIM_MAJ_EN
            smp   <= smp + 2'd1;
            votes <= votes + {1'b0, hit};
`endif
          end else if (b == '0) begin
            state    <= IDLE;
            code_out <= nxt;
            result   <= nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            // keep/clear the current bit, then try the next lower one
            state    <= TRIAL;
            code_out <= nxt | (bmask >> 1);
            b        <= b - 1'b1;
            cnt      <= CW'(SETTLE-1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fres_trim_sar.md
Name: fres_trim_sar

Overview:
- Clocked successive-approximation trim controller for a variable resistor element (EEnet resistor model with real-valued `rval` input).
- Drives `rval` from a digital code, waits a settling window per trial, samples an external comparator, and resolves the code MSB-first.
- Sits between the digital calibration sequencer and the analog resistor model. Also provides a manual override path for directed bring-up.

Parameters:
- CODE_W, 6, trim code width in bits (range 2..10).
- RMIN, 100.0, real; resistance in ohms for code 0.
- RSTEP, 10.0, real; ohms per LSB.
- SETTLE, 4, clock cycles held per trial before the comparator is sampled (>=1).
- CMP_POL, 1, 1: cmp=1 means resistance too high, clear the trial bit; 0: inverted sense.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a calibration when IDLE.
- cmp  input  1  comparator result from the analog side; synchronous to clk.
- ovr_en  input  1  manual override enable.
- ovr_code  input  CODE_W  code applied while ovr_en=1.
- code_out  output  CODE_W  code currently applied to the resistor.
- rval  output  real  RMIN + code_out*RSTEP; feeds the resistor model's rval input.
- busy  output  1  high from the cycle after start through the final sample.
- done  output  1  single-cycle pulse when a result is latched.
- result  output  CODE_W  last resolved code; holds until the next done.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, code_out=0, result=0, busy=0, done=0, rval=RMIN. rst has priority over every other input.
- rval update: recomputed combinationally from code_out; no added latency.
- IDLE:
  - code_out = ovr_en ? ovr_code : result.
  - start=1 and ovr_en=0 -> TRIAL with bit index b=CODE_W-1 and code_out = 1<<(CODE_W-1). busy=1 from the next cycle.
- TRIAL:
  - Settle counter loads SETTLE-1 on entry and decrements each cycle.
  - When the counter reaches 0 -> SAMPLE.
- SAMPLE (one cycle):
  - Sample cmp. If (cmp==CMP_POL), clear bit b; otherwise keep it.
  - If b>0: set bit b-1, b=b-1, return to TRIAL.
  - If b==0: result=final code, done=1 for one cycle, busy=0, state -> IDLE.
- Latency: start to done = 1 + CODE_W*(SETTLE+1) cycles. Default parameters give 31 cycles.
- Simultaneous events and boundaries:
  - start while busy: ignored; no restart, no error.
  - start with ovr_en=1 in IDLE: ignored; code_out follows ovr_code.
  - ovr_en asserted mid-calibration: calibration aborts; busy=0 the next cycle, no done, result unchanged, state -> IDLE, code_out=ovr_code.
  - rst mid-calibration: all outputs return to reset values on the next edge.
  - All-ones / all-zeros outcome (cmp stuck): result=2^CODE_W-1 or 0 respectively. No wrap, no flag.
- Arithmetic: code is unsigned. rval uses real arithmetic: $itor(code_out)*RSTEP + RMIN.

Optional Feature:
- Macro: FRES_TRIM_MAJ_EN.
- Defined:
  - Each SAMPLE becomes three consecutive sample cycles, and the bit decision is the 2-of-3 majority of cmp.
  - Latency becomes 1 + CODE_W*(SETTLE+3) cycles.
  - An abort during any sample cycle behaves as in the base mode.
- Undefined: single-sample decision as described in Behaviour.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> code_out=0, rval=100.0, busy=0, done=0, result=0.
- Binary search, default parameters: cmp model returns 1 when code_out>37; pulse start -> done at cycle 31, result=37, rval=470.0. Trial codes observed: 32, 48, 40, 36, 38, 37.
- Stuck comparator: cmp=0 constant -> result=63; cmp=1 constant -> result=0. Both complete in 31 cycles.
- Override: ovr_en=1, ovr_code=12 in IDLE -> code_out=12, rval=220.0, start ignored (busy stays 0). Separately, assert ovr_en at cycle 10 of a calibration -> busy=0 next cycle, no done, result unchanged.
- Back-to-back start: start pulsed again at cycles 5 and 20 during a calibration -> ignored, single done at cycle 31. A new start after done resolves again correctly.
- FRES_TRIM_MAJ_EN: cmp glitches to the wrong value for one of three samples each bit -> result still 37, done at cycle 43.
